// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
// Tag entries travel alongside each divider operation to route its result.
package div_sched_pkg;

   localparam int DATA_W = 16;
   localparam logic [DATA_W-1:0] DIVZERO_Q = 16'hFFFF;
   localparam logic [DATA_W-1:0] DIVZERO_D = 16'h0001;

   typedef struct packed {
      logic              valid;
      logic [2:0]        owner;
      logic              divzero;
      logic [DATA_W-1:0] numer;
   } div_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot grant, purely combinational (zero latency).
// No backpressure of its own; an empty request vector yields an all-zero grant.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt
);

   localparam int PTR_W = $clog2(N);

   always_comb begin
      int               s;
      logic [PTR_W-1:0] idx;
      logic             found;
      gnt   = '0;
      found = 1'b0;
      s     = 0;
      idx   = '0;
      for (int off = 0; off < N; off++) begin
         s = int'(ptr) + off;
         if (s >= N) s = s - N;
         idx = PTR_W'(s);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_sched.sv
// Shares one pipelined divider among N_REQ requesters; issue 1 cycle after transfer, response DIV_LAT+1 after.
// A grant is offered every cycle; responses have no backpressure and must be taken when strobed.
module div_sched
   import div_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DIV_LAT = 4
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [DATA_W*N_REQ-1:0] req_numer,
   input  logic [DATA_W*N_REQ-1:0] req_denom,
   output logic                    div_valid,
   output logic [DATA_W-1:0]       div_numer,
   output logic [DATA_W-1:0]       div_denom,
   input  logic [DATA_W-1:0]       div_quotient,
   input  logic [DATA_W-1:0]       div_remain,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_quotient,
   output logic [DATA_W-1:0]       rsp_remain,
   output logic                    rsp_divzero,
   output logic                    busy
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int N_STG = DIV_LAT + 1;

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0]  gnt;
   logic              xfer;
   logic [PTR_W-1:0]  gnt_idx;
   logic [DATA_W-1:0] sel_numer, sel_denom;
   logic              sel_zero;

   logic              div_valid_q, div_valid_d;
   logic [DATA_W-1:0] div_numer_q, div_numer_d;
   logic [DATA_W-1:0] div_denom_q, div_denom_d;

   div_tag_t          tag_q [N_STG];
   div_tag_t          tag_d [N_STG];
   div_tag_t          tail;

   logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_quotient_q, rsp_quotient_d;
   logic [DATA_W-1:0] rsp_remain_q, rsp_remain_d;
   logic              rsp_divzero_q, rsp_divzero_d;
   logic              busy_c;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .gnt (gnt)
   );

   // Grant is suppressed during reset so no transfer can land on a reset edge.
   assign req_ready = RESET ? '0 : gnt;
   assign xfer      = |(req_valid & req_ready);

   always_comb begin
      gnt_idx   = '0;
      sel_numer = '0;
      sel_denom = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            gnt_idx   = PTR_W'(i);
            sel_numer = req_numer[DATA_W*i +: DATA_W];
            sel_denom = req_denom[DATA_W*i +: DATA_W];
         end
      end
      sel_zero = (sel_denom == '0);
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);
      end
   end

   always_comb begin
      div_valid_d = xfer;
      div_numer_d = '0;
      div_denom_d = '0;
      if (xfer) begin
         div_numer_d = sel_numer;
         div_denom_d = sel_zero ? DIVZERO_D : sel_denom;
      end
   end

   always_comb begin
      tag_d[0]         = '0;
      tag_d[0].valid   = xfer;
      tag_d[0].owner   = 3'(gnt_idx);
      tag_d[0].divzero = xfer & sel_zero;
      tag_d[0].numer   = xfer ? sel_numer : '0;
      for (int j = 1; j < N_STG; j++) begin
         tag_d[j] = tag_q[j-1];
      end
   end

   assign tail = tag_q[N_STG-1];

   // The tail stage lines up with the divider output for the same operation.
   always_comb begin
      rsp_valid_d    = '0;
      rsp_quotient_d = '0;
      rsp_remain_d   = '0;
      rsp_divzero_d  = 1'b0;
      if (tail.valid) begin
         for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_d[i] = (tail.owner == 3'(i));
         end
         if (tail.divzero) begin
            rsp_quotient_d = DIVZERO_Q;
            rsp_remain_d   = tail.numer;
            rsp_divzero_d  = 1'b1;
         end else begin
            rsp_quotient_d = div_quotient;
            rsp_remain_d   = div_remain;
         end
      end
   end

   always_comb begin
      busy_c = div_valid_q;
      for (int j = 0; j < N_STG; j++) begin
         busy_c = busy_c | tag_q[j].valid;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rr_ptr_q       <= '0;
         div_valid_q    <= 1'b0;
         div_numer_q    <= '0;
         div_denom_q    <= '0;
         rsp_valid_q    <= '0;
         rsp_quotient_q <= '0;
         rsp_remain_q   <= '0;
         rsp_divzero_q  <= 1'b0;
         for (int j = 0; j < N_STG; j++) begin
            tag_q[j] <= '0;
         end
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         div_valid_q    <= div_valid_d;
         div_numer_q    <= div_numer_d;
         div_denom_q    <= div_denom_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_quotient_q <= rsp_quotient_d;
         rsp_remain_q   <= rsp_remain_d;
         rsp_divzero_q  <= rsp_divzero_d;
         for (int j = 0; j < N_STG; j++) begin
            tag_q[j] <= tag_d[j];
         end
      end
   end

   assign div_valid    = div_valid_q;
   assign div_numer    = div_numer_q;
   assign div_denom    = div_denom_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_quotient = rsp_quotient_q;
   assign rsp_remain   = rsp_remain_q;
   assign rsp_divzero  = rsp_divzero_q;
   assign busy         = busy_c;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: behavioural divider, round-robin reference model and
// a response scoreboard keyed by expected arrival cycle.
module tb_div_sched;

   localparam int N   = 4;
   localparam int LAT = 4;

   logic            CLK = 1'b0;
   logic            RESET;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [16*N-1:0] req_numer, req_denom;
   logic            div_valid;
   logic [15:0]     div_numer, div_denom, div_quotient, div_remain;
   logic [N-1:0]    rsp_valid;
   logic [15:0]     rsp_quotient, rsp_remain;
   logic            rsp_divzero, busy;

   div_sched #(.N_REQ(N), .DIV_LAT(LAT)) dut (
      .CLK(CLK), .RESET(RESET),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_numer(req_numer), .req_denom(req_denom),
      .div_valid(div_valid), .div_numer(div_numer), .div_denom(div_denom),
      .div_quotient(div_quotient), .div_remain(div_remain),
      .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remain(rsp_remain),
      .rsp_divzero(rsp_divzero), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Pipelined divider: operands sampled on an edge appear LAT-1 edges later.
   logic [15:0] dq [LAT];
   logic [15:0] dr [LAT];
   always @(posedge CLK) begin
      dq[0] <= (div_denom != 0) ? div_numer / div_denom : 16'hFFFF;
      dr[0] <= (div_denom != 0) ? div_numer % div_denom : div_numer;
      for (int j = 1; j < LAT; j++) begin
         dq[j] <= dq[j-1];
         dr[j] <= dr[j-1];
      end
   end
   assign div_quotient = dq[LAT-1];
   assign div_remain   = dr[LAT-1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int          due;
      int          owner;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
   } exp_t;

   exp_t        sb [$];
   int          cyc     = 0;
   int          m_ptr   = 0;
   logic        exp_rst = 1'b1;
   logic        iss_vld = 1'b0;
   logic [15:0] iss_n, iss_d;

   // Reference model: checks outputs produced by the last edge, then predicts the next edge.
   initial begin : monitor
      forever begin
         logic [N-1:0] eg;
         int           g;
         logic [15:0]  n, d;
         exp_t         e;
         @(negedge CLK);
         if (exp_rst) begin
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_q", rsp_quotient, 0);
            check("rst_rsp_r", rsp_remain, 0);
            check("rst_rsp_dz", rsp_divzero, 0);
            check("rst_div_numer", div_numer, 0);
            check("rst_div_denom", div_denom, 0);
         end
         if (iss_vld) begin
            check("div_valid", div_valid, 1);
            check("div_numer", div_numer, iss_n);
            check("div_denom", div_denom, iss_d);
         end else begin
            check("div_valid_idle", div_valid, 0);
         end
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rsp_valid", rsp_valid, 32'(1) << e.owner);
            check("rsp_quotient", rsp_quotient, e.q);
            check("rsp_remain", rsp_remain, e.r);
            check("rsp_divzero", rsp_divzero, e.dz);
         end else begin
            check("rsp_valid_idle", rsp_valid, 0);
         end
         check("busy", busy, sb.size() > 0);

         eg = '0;
         g  = -1;
         if (!RESET) begin
            for (int off = 0; off < N; off++) begin
               if (g < 0 && req_valid[(m_ptr + off) % N]) g = (m_ptr + off) % N;
            end
            if (g >= 0) eg[g] = 1'b1;
         end
         check("req_ready", req_ready, eg);
         if (RESET) begin
            exp_rst = 1'b1;
            iss_vld = 1'b0;
            sb.delete();
            m_ptr   = 0;
         end else begin
            exp_rst = 1'b0;
            iss_vld = (g >= 0);
            if (g >= 0) begin
               n       = req_numer[16*g +: 16];
               d       = req_denom[16*g +: 16];
               iss_n   = n;
               iss_d   = (d == 0) ? 16'd1 : d;
               e.due   = cyc + 1 + LAT + 1;
               e.owner = g;
               e.q     = (d == 0) ? 16'hFFFF : n / d;
               e.r     = (d == 0) ? n : n % d;
               e.dz    = (d == 0);
               sb.push_back(e);
               m_ptr   = (g + 1) % N;
            end
         end
         cyc++;
      end
   end

   int gq [$];

   task automatic set_req(input int i, input logic [15:0] n, input logic [15:0] d);
      req_numer[16*i +: 16] = n;
      req_denom[16*i +: 16] = d;
      req_valid[i]          = 1'b1;
   endtask

   // Drops each requester's valid after its transfer edge; records grant order.
   task automatic run_reqs(input int budget);
      int           k;
      logic [N-1:0] r;
      k = 0;
      gq.delete();
      while (req_valid != 0 && k < budget) begin
         @(negedge CLK);
         r = req_ready;
         for (int i = 0; i < N; i++) if (r[i]) gq.push_back(i);
         @(posedge CLK); #1;
         req_valid = req_valid & ~r;
         k++;
      end
      if (req_valid != 0) begin
         check("req_timeout", req_valid, 0);
         req_valid = '0;
      end
   endtask

   task automatic idle(input int c);
      repeat (c) @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [1:0] ptr0;
      RESET     = 1'b1;
      req_valid = '0;
      req_numer = '0;
      req_denom = '0;
      idle(3);
      RESET = 1'b0;
      idle(2);

      // Three simultaneous requesters from pointer 0.
      set_req(0, 16'd1001, 16'd11);
      set_req(1, 16'd500, 16'd7);
      set_req(2, 16'd65535, 16'd2);
      run_reqs(10);
      check("grant_cnt3", gq.size(), 3);
      if (gq.size() == 3) begin
         check("grant_a", gq[0], 0);
         check("grant_b", gq[1], 1);
         check("grant_c", gq[2], 2);
      end
      idle(8);

      set_req(0, 16'd1000, 16'd10);
      run_reqs(10);
      idle(8);

      // Two requesters held valid for 8 edges.
      req_valid = '0;
      set_req(1, 16'd500, 16'd7);
      set_req(3, 16'd9999, 16'd100);
      gq.delete();
      repeat (8) begin
         @(negedge CLK);
         for (int i = 0; i < N; i++) if (req_ready[i]) gq.push_back(i);
         @(posedge CLK); #1;
      end
      req_valid = '0;
      check("alt_cnt", gq.size(), 8);
      for (int k = 1; k < gq.size(); k++) check("alt_grant", gq[k], (gq[k-1] == 1) ? 3 : 1);
      if (gq.size() > 0) check("alt_ptr", dut.rr_ptr_q, (gq[gq.size()-1] == 3) ? 0 : 2);
      idle(8);

      set_req(2, 16'd1234, 16'd0);
      run_reqs(10);
      idle(8);

      // Reset while three operations are in flight.
      set_req(0, 16'd300, 16'd3);
      set_req(1, 16'd301, 16'd4);
      set_req(2, 16'd302, 16'd5);
      run_reqs(10);
      idle(1);
      RESET = 1'b1;
      idle(1);
      RESET = 1'b0;
      idle(10);
      set_req(3, 16'd4000, 16'd7);
      run_reqs(10);
      idle(8);

      ptr0 = dut.rr_ptr_q;
      idle(20);
      check("idle_ptr", dut.rr_ptr_q, ptr0);
      check("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/div_sched.md
# div_sched

Round-robin scheduler that shares one pipelined 16-bit unsigned divider among `N_REQ` requesters in the DDS datapath. It accepts numerator/denominator pairs over per-requester valid/ready handshakes and issues at most one operation per cycle to the divider. It tracks each in-flight operation's owner in a tag pipeline matched to the divider latency, and routes quotient/remainder back on a shared response bus with one-hot valid. Division by zero is intercepted; it never reaches the divider with a zero denominator.

## Interface
- `N_REQ`, 4 — number of requesters (2..8).
- `DIV_LAT`, 4 — divider latency in cycles from `div_valid` sampled to result valid (≥1).
- `CLK` in 1 — clock, rising edge.
- `RESET` in 1 — reset, synchronous, active-high.
- `req_valid` in `N_REQ` — request pending, one bit per requester.
- `req_ready` out `N_REQ` — one-hot grant (combinational from `req_valid` and pointer).
- `req_numer` in `16*N_REQ` — numerators; requester i at [16i+15:16i].
- `req_denom` in `16*N_REQ` — denominators, same packing.
- `div_valid` out 1 — operation issued to divider this cycle.
- `div_numer` out 16 — divider numerator.
- `div_denom` out 16 — divider denominator.
- `div_quotient` in 16 — divider quotient, valid `DIV_LAT` cycles after issue.
- `div_remain` in 16 — divider remainder.
- `rsp_valid` out `N_REQ` — one-hot response strobe, single cycle.
- `rsp_quotient` out 16 — response quotient.
- `rsp_remain` out 16 — response remainder.
- `rsp_divzero` out 1 — response came from a zero-denominator request.
- `busy` out 1 — at least one operation in flight.

## Operation
- Grant: rotating priority starting at `rr_ptr`; the first i (ascending, modulo `N_REQ`) with `req_valid[i]` gets `req_ready[i]=1`. At most one bit is set. The bus is all zeros when no request is valid.
- Handshake: a transfer occurs at the edge where `req_valid[i]&req_ready[i]`. On a transfer, `rr_ptr <= (i+1) mod N_REQ`. With no transfer, `rr_ptr` holds.
- A requester must hold its `req_valid`, numerator and denominator stable until the transfer. The scheduler has no stall; a grant is available every cycle.
- Issue (registered): after a transfer edge, `div_valid=1` and `div_numer`=granted numerator. `div_denom`=granted denominator, or 16'h0001 if it was zero.
- Tag pipeline: `DIV_LAT+1` stages of {valid, owner index, divzero flag, saved numerator}. It shifts every cycle and is loaded alongside `div_*`.
- Response (registered): when the tail stage is valid, set `rsp_valid[owner]=1`, `rsp_quotient=div_quotient` and `rsp_remain=div_remain`, with `rsp_divzero=0`.
- Division by zero overrides the response: `rsp_quotient=16'hFFFF`, `rsp_remain`=saved numerator, `rsp_divzero=1`.
- Responses have no backpressure. Consumers must accept `rsp_valid` in the cycle it is high.
- `busy` is the OR of all tag-stage valids and `div_valid`.

## Timing
- Reset values: all outputs 0, `rr_ptr=0`, all tag stages invalid. `req_ready` is combinational and follows `req_valid` from the first cycle after reset.
- Issue latency: transfer at edge k gives `div_valid` high from edge k until edge k+1.
- Response latency: `rsp_valid` goes high at edge k+DIV_LAT+1 and stays high one cycle.
- Throughput: one operation per cycle sustained. Back-to-back responses come out in issue order.
- `RESET` asserted mid-operation drops all in-flight operations. No `rsp_valid` occurs for them, even if the divider still emits results afterwards.
- While `RESET` is high, `req_ready` is forced to 0. No transfer occurs on a reset edge.
- Simultaneous requests are resolved by `rr_ptr` only. A requester that stays valid is granted within `N_REQ` cycles (starvation-free).
- Arithmetic is unsigned 16-bit. No width extension; the quotient is never truncated because the denominator is ≥1.

## Structure
- Package `div_sched_pkg`:
  - `DATA_W=16`, `DIVZERO_Q=16'hFFFF`, `DIVZERO_D=16'h0001`.
  - Packed struct `div_tag_t` {valid, owner[2:0], divzero, numer[15:0]}.
- Sub-module `rr_arbiter` (params `N`; ports `req`, `ptr`, `gnt`): purely combinational rotating-priority one-hot grant. Pointer update stays in `div_sched`.
- The tag pipeline is an array of `div_tag_t` in `div_sched`. It is not a separate module.

## Test plan
- `N_REQ=4`, `DIV_LAT=4`, requester 0 sends 1000/10 at edge k:
  - `div_*`=1000/10 valid at k+1.
  - `rsp_valid=4'b0001`, q=100, r=0 at k+5.
- Requesters 0, 1, 2 valid together holding 1001/11, 500/7, 65535/2:
  - grants 0, 1, 2 on consecutive edges;
  - responses on consecutive cycles: q=91 r=0; q=71 r=3; q=32767 r=1.
- Requesters 1 and 3 valid continuously for 8 edges:
  - grants alternate 1, 3, 1, 3…;
  - `rr_ptr` after the final grant is 0 (last grant to 3) or 2 (last grant to 1).
- Requester 2 sends 1234/0:
  - `div_denom=1`;
  - response has `rsp_valid[2]`, q=16'hFFFF, r=1234, `rsp_divzero=1`.
- Three operations in flight, then `RESET` pulsed one cycle:
  - no `rsp_valid` for the dropped operations;
  - all outputs 0 and `busy=0` after the reset edge;
  - the next request returns its response normally.
- No requests for 20 cycles: `req_ready`, `div_valid`, `rsp_valid` and `busy` stay 0, and `rr_ptr` holds.
